// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// the default halt-word fill bit.
package if_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalted
  } if_state_e;

  // The default halt word is every bit set, whatever the instruction width.
  localparam logic DefaultHaltFill = 1'b1;

endpackage

// File: rtl/instruction_fetch_unit_bram.sv
// Single-port block RAM with synchronous read; a write suppresses the read
// and leaves the read port unchanged.
module instruction_fetch_unit_bram #(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned DATA_BITS    = 32
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDRESS_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0]    wdata_i,
  output logic [DATA_BITS-1:0]    rdata_o
);

  logic [DATA_BITS-1:0] mem_q [2**ADDRESS_BITS];
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and instruction memory, qualifies BRAM output with
// a valid bit, squashes on redirect, holds output through stalls.
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned           PC_WIDTH   = 8,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] HALT_WORD  = {INST_WIDTH{DefaultHaltFill}},
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  PCSrc,
  input  logic [PC_WIDTH-1:0]   PCBranch,
  input  logic                  write_inst_mem,
  input  logic [PC_WIDTH-1:0]   inst_mem_addr,
  input  logic [INST_WIDTH-1:0] inst_mem_data,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]   PCNext,
  output logic                  inst_valid,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  if_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_next_q, pc_next_d;
  logic                  valid_q, valid_d;
  logic                  fresh_q, fresh_d;
  logic [INST_WIDTH-1:0] hold_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rd_en;
  logic [PC_WIDTH-1:0]   mem_addr;
  logic [INST_WIDTH-1:0] rdata;

  assign mem_addr = write_inst_mem ? inst_mem_addr : pc_q;

  instruction_fetch_unit_bram #(
    .ADDRESS_BITS(PC_WIDTH),
    .DATA_BITS   (INST_WIDTH)
  ) u_bram (
    .clk_i  (clk),
    .en_i   (rd_en),
    .we_i   (write_inst_mem),
    .addr_i (mem_addr),
    .wdata_i(inst_mem_data),
    .rdata_o(rdata)
  );

  // BRAM output is only trusted the cycle after a read; otherwise replay the
  // last presented word so stalls and bubbles stay bit-exact.
  assign instruction = fresh_q ? rdata : hold_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    fresh_d   = 1'b0;
    rd_en     = 1'b0;
    count_d   = count_q;

    if (enable && valid_q && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end

    if (write_inst_mem) begin
      state_d = StIdle;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (enable) begin
      valid_d = 1'b0;
      if (start) begin
        state_d = StFetch;
        pc_d    = '0;
        count_d = '0;
      end else if (state_q == StFetch) begin
        if (PCSrc) begin
          // Redirect: the sequential read is not issued, giving one bubble.
          pc_d = PCBranch;
        end else if (valid_q && (instruction == HALT_WORD)) begin
          state_d = StHalted;
        end else begin
          rd_en     = 1'b1;
          fresh_d   = 1'b1;
          valid_d   = 1'b1;
          pc_d      = pc_q + PC_WIDTH'(1);
          pc_next_d = pc_q + PC_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      hold_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      hold_q    <= instruction;
      count_q   <= count_d;
    end
  end

  assign PCNext      = pc_next_q;
  assign inst_valid  = valid_q;
  assign halted      = (state_q == StHalted);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed/randomized bench for instruction_fetch_unit; expected words come
// from a reference copy of memory and the fetch-order rules.
module tb_instruction_fetch_unit;

  localparam int unsigned PW = 8;
  localparam int unsigned IW = 32;
  localparam int unsigned CW = 4;
  localparam logic [IW-1:0] HALT = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          enable = 1'b0;
  logic          PCSrc = 1'b0;
  logic [PW-1:0] PCBranch = '0;
  logic          write_inst_mem = 1'b0;
  logic [PW-1:0] inst_mem_addr = '0;
  logic [IW-1:0] inst_mem_data = '0;
  logic [IW-1:0] instruction;
  logic [PW-1:0] PCNext;
  logic          inst_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  bit pres     = 1'b0;  // model: a valid word is presented this cycle
  logic [IW-1:0] ref_mem [256];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .PC_WIDTH  (PW),
    .INST_WIDTH(IW),
    .HALT_WORD (HALT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .enable        (enable),
    .PCSrc         (PCSrc),
    .PCBranch      (PCBranch),
    .write_inst_mem(write_inst_mem),
    .inst_mem_addr (inst_mem_addr),
    .inst_mem_data (inst_mem_data),
    .instruction   (instruction),
    .PCNext        (PCNext),
    .inst_valid    (inst_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock; the model counts a consumed word when enable and a valid word coincide.
  task automatic step();
    if (enable && pres) exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
    tick();
  endtask

  task automatic load(input logic [PW-1:0] a, input logic [IW-1:0] d);
    write_inst_mem = 1'b1;
    inst_mem_addr  = a;
    inst_mem_data  = d;
    ref_mem[a]     = d;
    tick();
    write_inst_mem = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [PW-1:0] a);
    logic [PW-1:0] nx;
    nx = a + 8'd1;
    chk({tag, "_valid"}, inst_valid, 1);
    chk({tag, "_inst"}, instruction, ref_mem[a]);
    chk({tag, "_pcnext"}, PCNext, nx);
    chk({tag, "_count"}, fetch_count, exp_cnt);
  endtask

  task automatic do_start();
    enable = 1'b1;
    start  = 1'b1;
    step();
    start   = 1'b0;
    exp_cnt = 0;
    pres    = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_inst"}, instruction, 0);
    chk({tag, "_pcnext"}, PCNext, 0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_count"}, fetch_count, 0);
  endtask

  initial begin
    logic [PW-1:0] a;

    #2;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Load, start and run to the halt word.
    load(8'h00, 32'h11);
    load(8'h01, 32'h22);
    load(8'h02, 32'h33);
    load(8'h03, HALT);
    do_start();
    chk("start_bubble", inst_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      pres = 1'b1;
      expect_word("run", PW'(i));
    end
    step();
    pres = 1'b0;
    chk("halt_state", halted, 1);
    chk("halt_valid", inst_valid, 0);
    chk("halt_count", fetch_count, 4);
    step();
    chk("halt_hold_state", halted, 1);
    chk("halt_hold_valid", inst_valid, 0);

    // Random program; redirect, stall, saturation.
    for (int i = 0; i < 10; i++) load(PW'(i), $urandom & 32'h7FFF_FFFF);
    for (int i = 0; i < 24; i++) load(PW'(8'h40 + i), $urandom & 32'h7FFF_FFFF);
    do_start();
    chk("restart_halted", halted, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      pres = 1'b1;
      expect_word("seq", PW'(i));
    end
    PCSrc    = 1'b1;
    PCBranch = 8'h40;
    step();
    PCSrc = 1'b0;
    pres  = 1'b0;
    chk("redir_bubble", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      pres = 1'b1;
      expect_word("target", PW'(8'h40 + i));
    end
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin
        PCSrc    = 1'b1;
        PCBranch = 8'h10;
        start    = 1'b1;
      end
      step();
      PCSrc = 1'b0;
      start = 1'b0;
      expect_word("stall", 8'h42);
    end
    enable = 1'b1;
    step();
    expect_word("release", 8'h43);
    for (int i = 8'h44; i <= 8'h50; i++) begin
      step();
      expect_word("sat_run", PW'(i));
    end
    chk("count_saturated", fetch_count, 15);

    // Wrap-around, then halt word coinciding with a redirect.
    for (int i = 0; i < 3; i++) load(PW'(8'hFD + i), $urandom & 32'h7FFF_FFFF);
    load(8'h00, $urandom & 32'h7FFF_FFFF);
    load(8'h01, HALT);
    do_start();
    PCSrc    = 1'b1;
    PCBranch = 8'hFD;
    step();
    PCSrc = 1'b0;
    chk("wrap_bubble", inst_valid, 0);
    a = 8'hFD;
    for (int i = 0; i < 5; i++) begin
      step();
      pres = 1'b1;
      expect_word("wrap", a);
      a = a + 8'd1;
    end
    PCSrc    = 1'b1;
    PCBranch = 8'h40;
    step();
    PCSrc = 1'b0;
    pres  = 1'b0;
    chk("hvr_not_halted", halted, 0);
    chk("hvr_bubble", inst_valid, 0);
    step();
    pres = 1'b1;
    expect_word("hvr_target", 8'h40);
    chk("hvr_still_fetch", halted, 0);

    // Loader write during FETCH (even with enable low) drops to IDLE.
    enable         = 1'b0;
    write_inst_mem = 1'b1;
    inst_mem_addr  = 8'h80;
    inst_mem_data  = $urandom & 32'h7FFF_FFFF;
    ref_mem[8'h80] = inst_mem_data;
    step();
    write_inst_mem = 1'b0;
    pres           = 1'b0;
    chk("write_valid", inst_valid, 0);
    chk("write_halted", halted, 0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_wait_valid", inst_valid, 0);
    end
    do_start();
    PCSrc    = 1'b1;
    PCBranch = 8'h80;
    step();
    PCSrc = 1'b0;
    step();
    pres = 1'b1;
    expect_word("written_word", 8'h80);

    // Asynchronous reset mid-fetch; memory survives it.
    #2;
    rst = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst  = 1'b1;
    pres = 1'b0;
    tick();
    do_start();
    step();
    pres = 1'b1;
    expect_word("post_reset", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
